// File: rtl/reg_file_16x32.sv
`timescale 1ns/1ps
// reg_file_16x32: 16-entry general-purpose register file with two combinational
// read ports (rs/rt), one synchronous write port and a saturating write counter.
// The write index is decoded to a one-hot enable vector through two 2-to-4
// stages. Optional hardwired-zero r0 and same-cycle write-to-read forwarding.
module reg_file_16x32 #(
  parameter int                DATA_W  = 32,
  parameter int                ZERO_R0 = 1,
  parameter int                BYPASS  = 1,
  parameter logic [DATA_W-1:0] SP_INIT = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rs_addr,
  input  logic [3:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [15:0]       wr_sel,
  output logic [15:0]       wr_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] regs [16];
  logic [3:0]        dec_hi;
  logic [3:0]        dec_lo;
  logic              fwd_ok;

  // Two-level write decode: upper index bits pick a bank of four (gated by
  // wr_en), lower bits pick the register within the bank.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional or indexed assignment, so no path leaves a value held (latch).
    dec_hi = 4'b0000;
    dec_lo = 4'b0000;
    wr_sel = 16'h0000;
    dec_hi[wr_addr[3:2]] = wr_en;
    dec_lo[wr_addr[1:0]] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        wr_sel[4*i + j] = dec_hi[i] & dec_lo[j];
      end
    end
  end

  // Register storage: asynchronous reset to 0 (r15 to SP_INIT), then one
  // register loads wr_data per enabled edge; r0 is read-only when hardwired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is deliberately reset (a RAM macro would not be); the
      // reset contents, including the stack-pointer value in r15, are
      // architecturally visible.
      for (int k = 0; k < 16; k++) begin
        regs[k] <= (k == 15) ? SP_INIT : {DATA_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (wr_sel[k] && !((ZERO_R0 != 0) && (k == 0))) begin
          // NOTE: state is updated with non-blocking assignments so every
          // flop samples pre-edge values regardless of statement order.
          regs[k] <= wr_data;
        end
      end
    end
  end

  // Debug counter of accepted write requests; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= 16'h0000;
    end else if (wr_en && (wr_cnt != CNT_MAX)) begin
      wr_cnt <= wr_cnt + 16'd1;
    end
  end

  // Read ports: hardwired zero beats forwarding, forwarding beats storage.
  always_comb begin
    fwd_ok  = (BYPASS != 0) && wr_en && !rst;
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (fwd_ok && (rs_addr == wr_addr)) rs_data = wr_data;
    if (fwd_ok && (rt_addr == wr_addr)) rt_data = wr_data;
    if ((ZERO_R0 != 0) && (rs_addr == 4'd0)) rs_data = {DATA_W{1'b0}};
    if ((ZERO_R0 != 0) && (rt_addr == 4'd0)) rt_data = {DATA_W{1'b0}};
  end

endmodule

// File: tb/tb_reg_file_16x32.sv
`timescale 1ns/1ps
// tb_reg_file_16x32: directed test of reg_file_16x32. Two instances share all
// inputs: dut_a uses ZERO_R0=1, BYPASS=1, SP_INIT=0; dut_b uses ZERO_R0=0,
// BYPASS=0, SP_INIT=32'h0000_0FFC. Outputs are sampled 1 ns after clk edges.
module tb_reg_file_16x32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rs_addr;
  logic [3:0]  rt_addr;
  logic [31:0] rs_a, rt_a, rs_b, rt_b;
  logic [15:0] sel_a, sel_b, cnt_a, cnt_b;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] SP_B = 32'h0000_0FFC;

  reg_file_16x32 #(.DATA_W(32), .ZERO_R0(1), .BYPASS(1), .SP_INIT(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_a), .rt_data(rt_a),
    .wr_sel(sel_a), .wr_cnt(cnt_a)
  );

  reg_file_16x32 #(.DATA_W(32), .ZERO_R0(0), .BYPASS(0), .SP_INIT(SP_B)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_b), .rt_data(rt_b),
    .wr_sel(sel_b), .wr_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_v;
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'h0;
    rs_addr = 4'd0; rt_addr = 4'd0;

    // Reset contents on both ports, both configurations.
    #12;
    for (int k = 0; k < 16; k++) begin
      rs_addr = 4'(k); rt_addr = 4'(k);
      #1;
      check($sformatf("rst_a_rs%0d", k), rs_a, 32'h0);
      check($sformatf("rst_a_rt%0d", k), rt_a, 32'h0);
      check($sformatf("rst_b_rs%0d", k), rs_b, (k == 15) ? SP_B : 32'h0);
      check($sformatf("rst_b_rt%0d", k), rt_b, (k == 15) ? SP_B : 32'h0);
    end
    check("rst_cnt_a", {16'h0, cnt_a}, 32'h0);
    check("rst_cnt_b", {16'h0, cnt_b}, 32'h0);
    check("idle_sel_a", {16'h0, sel_a}, 32'h0);
    tick();
    rst = 1'b0;

    // Write DEADBEEF to r5.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    #1;
    check("sel_r5_a", {16'h0, sel_a}, 32'h0000_0020);
    check("sel_r5_b", {16'h0, sel_b}, 32'h0000_0020);
    tick();
    wr_en = 1'b0; rs_addr = 4'd5; rt_addr = 4'd5;
    #1;
    check("r5_rs_a", rs_a, 32'hDEADBEEF);
    check("r5_rt_a", rt_a, 32'hDEADBEEF);
    check("r5_rs_b", rs_b, 32'hDEADBEEF);
    check("r5_rt_b", rt_b, 32'hDEADBEEF);
    check("cnt1_a", {16'h0, cnt_a}, 32'd1);

    // Write to r0: hardwired in dut_a (even under bypass), ordinary in dut_b.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h12345678; rs_addr = 4'd0;
    #1;
    check("sel_r0_a", {16'h0, sel_a}, 32'h0000_0001);
    check("r0_byp_a", rs_a, 32'h0);
    check("r0_old_b", rs_b, 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    check("r0_a", rs_a, 32'h0);
    check("r0_b", rs_b, 32'h12345678);
    check("cnt2_a", {16'h0, cnt_a}, 32'd2);

    // Same-cycle read/write of r7: old 1, new 2.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h1;
    tick();
    wr_data = 32'h2; rs_addr = 4'd7; rt_addr = 4'd7;
    #1;
    check("r7_byp_rs_a", rs_a, 32'h2);
    check("r7_byp_rt_a", rt_a, 32'h2);
    check("r7_old_rs_b", rs_b, 32'h1);
    tick();
    wr_en = 1'b0;
    #1;
    check("r7_new_a", rs_a, 32'h2);
    check("r7_new_b", rs_b, 32'h2);
    check("cnt4_b", {16'h0, cnt_b}, 32'd4);

    // Write r3, then assert reset mid-cycle with another r3 write pending.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5A5A5; rs_addr = 4'd3; rt_addr = 4'd15;
    tick();
    wr_data = 32'hFFFF0000;
    #1;
    check("r3_pre_b", rs_b, 32'hA5A5A5A5);
    #1;
    rst = 1'b1;
    #1;
    check("r3_rst_a", rs_a, 32'h0);
    check("r3_rst_b", rs_b, 32'h0);
    check("r15_rst_b", rt_b, SP_B);
    check("cnt_rst_a", {16'h0, cnt_a}, 32'h0);
    check("cnt_rst_b", {16'h0, cnt_b}, 32'h0);
    check("sel_in_rst_a", {16'h0, sel_a}, 32'h0000_0008);
    tick();
    check("r3_hold_a", rs_a, 32'h0);
    check("r3_hold_b", rs_b, 32'h0);
    check("cnt_hold_a", {16'h0, cnt_a}, 32'h0);
    rst = 1'b0; wr_en = 1'b0;
    #1;
    check("r3_post_b", rs_b, 32'h0);

    // Back-to-back writes r15..r0 with data k*0x11111111; the r15 write lands on
    // the first edge after reset release.
    for (int k = 15; k >= 0; k--) begin
      wr_en = 1'b1; wr_addr = 4'(k); wr_data = 32'(k) * 32'h11111111;
      #1;
      if (k == 15 || k == 8 || k == 0)
        check($sformatf("sel_b2b_%0d", k), {16'h0, sel_b}, 32'h1 << k);
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rs_addr = 4'(k); rt_addr = 4'(15 - k);
      #1;
      exp_v = 32'(k) * 32'h11111111;
      check($sformatf("pair_rs_a%0d", k), rs_a, exp_v);
      check($sformatf("pair_rs_b%0d", k), rs_b, exp_v);
      exp_v = 32'(15 - k) * 32'h11111111;
      check($sformatf("pair_rt_a%0d", 15 - k), rt_a, exp_v);
      check($sformatf("pair_rt_b%0d", 15 - k), rt_b, exp_v);
    end
    check("cnt16_a", {16'h0, cnt_a}, 32'd16);

    // Drive the counter to FFFE, then two more writes must stick at FFFF.
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hCAFE0001;
    repeat (16'hFFFE - 16) @(posedge clk);
    #1;
    check("cnt_fffe_a", {16'h0, cnt_a}, 32'h0000_FFFE);
    tick();
    check("cnt_sat1_a", {16'h0, cnt_a}, 32'h0000_FFFF);
    tick();
    check("cnt_sat2_a", {16'h0, cnt_a}, 32'h0000_FFFF);
    check("cnt_sat2_b", {16'h0, cnt_b}, 32'h0000_FFFF);
    wr_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_16x32.md
Name: reg_file_16x32

Overview:
- 16-entry by DATA_W general-purpose register file for the MIPS32-subset datapath.
- Consumes the 4-bit destination register index. Decodes it internally to a 16-bit one-hot, active-high write-enable vector using two-level 2-to-4 decode, gated by wr_en.
- Each enable line updates one register on the clock edge.
- Sits between writeback (wr_*) and operand fetch (rs/rt read ports); feeds the ALU operand muxes.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ZERO_R0, 1, when 1 register 0 always reads 0 and ignores writes; when 0 it is an ordinary register.
- BYPASS, 1, when 1 a read of the register being written in the same cycle returns wr_data; when 0 it returns the stored (old) value.
- SP_INIT, 32'h0000_0000, reset value of register 15 (stack pointer); all other registers reset to 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request, sampled at posedge clk.
- wr_addr  input  4  destination register index.
- wr_data  input  DATA_W  write data.
- rs_addr  input  4  read port A index.
- rt_addr  input  4  read port B index.
- rs_data  output  DATA_W  read port A data, combinational.
- rt_data  output  DATA_W  read port B data, combinational.
- wr_sel  output  16  one-hot decoded write enables, combinational: bit k = wr_en & (wr_addr==k). All zeros when wr_en=0.
- wr_cnt  output  16  saturating count of committed writes, for debug.

Behaviour:
- Reset: asserting rst immediately (asynchronously) forces regs 0..14 to 0, reg 15 to SP_INIT, and wr_cnt to 0.
  - rs_data and rt_data then reflect the reset contents combinationally.
  - wr_sel is purely combinational and is not affected by reset.
- While rst is high, no write commits regardless of wr_en.
- Deassertion of rst is used synchronously by the system. A wr_en present on the first posedge after deassertion commits normally.
- Write: at posedge clk with rst=0, the register k with wr_sel[k]=1 loads wr_data.
  - At most one wr_sel bit is ever high.
  - Latency is 1 cycle: the new value is visible from the stored array after that edge.
- Write to reg 0 when ZERO_R0=1:
  - wr_sel[0] still asserts.
  - Storage is unchanged.
  - wr_cnt still increments, because the counter counts requests accepted.
- Reads: rs_data = content[rs_addr] and rt_data = content[rt_addr], combinational, both ports independent.
  - rs_addr == rt_addr is legal; both ports return identical data.
- ZERO_R0=1: any read of index 0 returns 0, including under bypass.
- Bypass (BYPASS=1): if wr_en=1, rst=0 and read addr == wr_addr (and the index is not r0 with ZERO_R0=1), the port returns wr_data in the same cycle.
  - Forwarding applies to both ports simultaneously when both match.
- BYPASS=0: reads return the pre-edge stored value until the edge.
- wr_cnt: increments by 1 at each posedge with wr_en=1 and rst=0. It saturates at 16'hFFFF and does not wrap.
- X-safety: wr_addr is fully decoded (all 16 codes valid); there are no illegal states.
- Reset mid-write: if rst rises in the same cycle as wr_en, reset wins; the target register holds its reset value.

Test Plan:
- Reset, then read all 16 indices on rs and rt -> regs 0..14 read 0 and reg 15 reads SP_INIT. Repeat with SP_INIT=32'h0000_0FFC -> reg 15 reads 32'h0000_0FFC.
- Write 32'hDEADBEEF to r5, then on the next cycle read rs=5, rt=5 -> both 32'hDEADBEEF, wr_cnt=1. Check wr_sel during the write cycle = 16'h0020.
- ZERO_R0=1: write 32'h12345678 to r0 -> wr_sel=16'h0001 and r0 still reads 0. Same test with ZERO_R0=0 -> r0 reads 32'h12345678.
- Same-cycle read/write of r7 (old value 32'h1, wr_data 32'h2):
  - BYPASS=1 -> rs_data=32'h2 in that cycle.
  - BYPASS=0 -> rs_data=32'h1 in that cycle and 32'h2 after the edge.
- Assert rst asynchronously mid-cycle after writing r3=32'hA5A5A5A5, with wr_en=1 to r3 pending -> r3 reads 0 immediately and wr_cnt=0. After release, no stale write appears.
- Write all 16 registers back-to-back with data = index*0x11111111, then read pairs (k, 15-k) -> correct values. With the counter forced near max, 2 extra writes -> wr_cnt holds at 16'hFFFF.
